// File: rtl/abcn_ro_pkg.sv
// Shared definitions for the readout request scheduler: ratio codes,
// default sizing and the scheduler state encoding.
package abcn_ro_pkg;

  localparam logic [1:0] RATIO_1 = 2'b00;
  localparam logic [1:0] RATIO_2 = 2'b01;
  localparam logic [1:0] RATIO_4 = 2'b10;

  localparam int PEND_W_DEF    = 4;
  localparam int HOLD_MULT_DEF = 3;
  // Holdoff counter width; holds HOLD_MULT_DEF*4-1 = 11.
  localparam int HOLD_W        = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    HOLDOFF = 1'b1
  } schedState_e;

  // The reserved code 2'b11 is treated as the slowest ratio.
  function automatic logic [2:0] ratio_to_r(input logic [1:0] sel);
    case (sel)
      RATIO_1: ratio_to_r = 3'd1;
      RATIO_2: ratio_to_r = 3'd2;
      RATIO_4: ratio_to_r = 3'd4;
      default: ratio_to_r = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/holdoff_timer.sv
// Loadable down-counter that measures the post-pulse holdoff window.
// done is high whenever the count has reached zero.
module holdoff_timer
  import abcn_ro_pkg::*;
(
  input  logic              clk,
  input  logic              rstb,
  input  logic              load,
  input  logic [HOLD_W-1:0] loadVal,
  output logic              done
);

  logic [HOLD_W-1:0] holdCnt;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      holdCnt <= '0;
    end else if (load) begin
      holdCnt <= loadVal;
    end else if (holdCnt != '0) begin
      holdCnt <= holdCnt - HOLD_W'(1);
    end
  end

  assign done = (holdCnt == '0);

endmodule

// File: rtl/readout_req_sched.sv
// Readout request scheduler: counts trigger requests and issues spaced
// single-clk read-enables while the event FIFO holds data.
//
// state   | meaning
// IDLE    | waiting for pending request, enable and non-empty FIFO
// HOLDOFF | pulse issued; counting down so the downstream stretcher clears
module readout_req_sched
  import abcn_ro_pkg::*;
#(
  parameter int PEND_W    = PEND_W_DEF,
  parameter int HOLD_MULT = HOLD_MULT_DEF
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic [1:0]        ratioSel,
  input  logic              enable,
  input  logic              trigI,
  input  logic              fifoEmpty,
  input  logic              clrOvf,
  output logic              reI,
  output logic [PEND_W-1:0] pendCnt,
  output logic              busy,
  output logic              overflow
);

  schedState_e       state, stateNext;
  logic              issue;
  logic              holdDone;
  logic              pendFull;
  logic              ovfEvent;
  logic [HOLD_W-1:0] holdLoad;

  // Ratio is captured only on the issue edge through the timer load.
  assign holdLoad = HOLD_W'(HOLD_MULT * int'(ratio_to_r(ratioSel)) - 1);
  assign pendFull = (pendCnt == {PEND_W{1'b1}});
  assign ovfEvent = trigI && pendFull && !issue;
  assign busy     = (state == HOLDOFF);

  holdoff_timer u_holdTimer (
    .clk     (clk),
    .rstb    (rstb),
    .load    (issue),
    .loadVal (holdLoad),
    .done    (holdDone)
  );

  always_comb begin
    stateNext = state;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (enable && (pendCnt != '0) && !fifoEmpty) begin
          issue     = 1'b1;
          stateNext = HOLDOFF;
        end
      end
      HOLDOFF: begin
        if (holdDone) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state    <= IDLE;
      reI      <= 1'b0;
      pendCnt  <= '0;
      overflow <= 1'b0;
    end else begin
      state <= stateNext;
      reI   <= issue;
      if (trigI && !issue && !pendFull) begin
        pendCnt <= pendCnt + PEND_W'(1);
      end else if (issue && !trigI) begin
        pendCnt <= pendCnt - PEND_W'(1);
      end
      // A fresh overflow event takes priority over a clear on the same edge.
      if (ovfEvent) begin
        overflow <= 1'b1;
      end else if (clrOvf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_readout_req_sched.sv
// Directed self-checking bench for readout_req_sched; inputs change and
// outputs are sampled 1 time unit after each rising clk edge.
module tb_readout_req_sched;

  logic       clk;
  logic       rstb;
  logic [1:0] ratioSel;
  logic       enable;
  logic       trigI;
  logic       fifoEmpty;
  logic       clrOvf;
  logic       reI;
  logic [3:0] pendCnt;
  logic       busy;
  logic       overflow;

  int testCnt = 0;
  int failCnt = 0;

  readout_req_sched dut (
    .clk       (clk),
    .rstb      (rstb),
    .ratioSel  (ratioSel),
    .enable    (enable),
    .trigI     (trigI),
    .fifoEmpty (fifoEmpty),
    .clrOvf    (clrOvf),
    .reI       (reI),
    .pendCnt   (pendCnt),
    .busy      (busy),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input int got, input int exp);
    testCnt++;
    if (got !== exp) begin
      failCnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rstb   = 1'b0;
    trigI  = 1'b0;
    clrOvf = 1'b0;
    tick();
    rstb = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int expGap [4] = '{4, 7, 13, 13};
  int nPulse;
  int lastIdx;
  int sawRe;
  int waitCyc;

  initial begin
    rstb = 1'b0; ratioSel = 2'b00; enable = 1'b0; trigI = 1'b0;
    fifoEmpty = 1'b0; clrOvf = 1'b0;

    // Reset and single-trigger latency at R=1
    tick(); tick(); tick();
    checkVal("rst_reI", reI, 0);
    checkVal("rst_pend", pendCnt, 0);
    checkVal("rst_busy", busy, 0);
    checkVal("rst_ovf", overflow, 0);
    rstb = 1'b1; enable = 1'b1;
    tick();
    trigI = 1'b1;
    tick();
    trigI = 1'b0;
    checkVal("lat_pend_k", pendCnt, 1);
    checkVal("lat_reI_k", reI, 0);
    tick();
    checkVal("lat_reI_k1", reI, 1);
    checkVal("lat_pend_k1", pendCnt, 0);
    checkVal("lat_busy1", busy, 1);
    tick();
    checkVal("lat_reI_k2", reI, 0);
    checkVal("lat_busy2", busy, 1);
    tick();
    checkVal("lat_busy3", busy, 1);
    tick();
    checkVal("lat_busy_end", busy, 0);

    // Pulse spacing per ratio, including the reserved code
    doReset();
    for (int s = 0; s < 4; s++) begin
      ratioSel = 2'(s);
      enable = 1'b0;
      trigI = 1'b1;
      tick(); tick(); tick();
      trigI = 1'b0;
      checkVal($sformatf("preload_r%0d", s), pendCnt, 3);
      enable = 1'b1;
      nPulse = 0;
      lastIdx = 0;
      for (int c = 0; c < 50; c++) begin
        tick();
        if (reI) begin
          if (nPulse > 0) checkVal($sformatf("gap_r%0d", s), c - lastIdx, expGap[s]);
          checkVal($sformatf("step_r%0d", s), pendCnt, 2 - nPulse);
          lastIdx = c;
          nPulse++;
        end
      end
      checkVal($sformatf("npulse_r%0d", s), nPulse, 3);
    end

    // Saturation and overflow set/clear priority
    doReset();
    enable = 1'b0;
    trigI = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    checkVal("sat_pend15", pendCnt, 15);
    checkVal("sat_ovf_pre", overflow, 0);
    tick();
    checkVal("sat_pend16", pendCnt, 15);
    checkVal("sat_ovf16", overflow, 1);
    clrOvf = 1'b1;
    tick();
    checkVal("sat_clr_vs_set", overflow, 1);
    trigI = 1'b0;
    tick();
    checkVal("sat_clr", overflow, 0);
    checkVal("sat_pend_hold", pendCnt, 15);
    clrOvf = 1'b0;

    // Trigger on the issue edge leaves the count unchanged
    doReset();
    ratioSel = 2'b00;
    enable = 1'b0;
    trigI = 1'b1;
    tick(); tick();
    checkVal("sim_pre", pendCnt, 2);
    enable = 1'b1;
    tick();
    trigI = 1'b0;
    checkVal("sim_reI", reI, 1);
    checkVal("sim_pend", pendCnt, 2);

    // FIFO-empty gating, then enable dropped mid-holdoff
    doReset();
    enable = 1'b1;
    fifoEmpty = 1'b1;
    trigI = 1'b1;
    tick(); tick();
    trigI = 1'b0;
    checkVal("gate_pend", pendCnt, 2);
    sawRe = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (reI) sawRe = 1;
    end
    checkVal("gate_noRe", sawRe, 0);
    fifoEmpty = 1'b0;
    tick();
    checkVal("gate_reI", reI, 1);
    checkVal("gate_pend1", pendCnt, 1);
    enable = 1'b0;
    fifoEmpty = 1'b1;
    tick();
    checkVal("en_busy_mid", busy, 1);
    fifoEmpty = 1'b0;
    waitCyc = 0;
    while (busy && waitCyc < 20) begin
      tick();
      waitCyc++;
    end
    checkVal("en_busy_done", busy, 0);
    sawRe = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (reI || busy) sawRe = 1;
    end
    checkVal("en_noRe", sawRe, 0);
    checkVal("en_pend_held", pendCnt, 1);

    // Reset in the middle of a holdoff
    doReset();
    ratioSel = 2'b10;
    enable = 1'b0;
    trigI = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    trigI = 1'b0;
    enable = 1'b1;
    tick();
    checkVal("mid_reI", reI, 1);
    checkVal("mid_pend5", pendCnt, 5);
    tick();
    checkVal("mid_busy", busy, 1);
    rstb = 1'b0;
    tick();
    checkVal("mid_rst_pend", pendCnt, 0);
    checkVal("mid_rst_busy", busy, 0);
    checkVal("mid_rst_reI", reI, 0);
    checkVal("mid_rst_ovf", overflow, 0);
    rstb = 1'b1;
    sawRe = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (reI) sawRe = 1;
    end
    checkVal("mid_noRe", sawRe, 0);
    trigI = 1'b1;
    tick();
    trigI = 1'b0;
    tick();
    checkVal("mid_newRe", reI, 1);

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule

// File: doc/readout_req_sched.md
Name: readout_req_sched

Overview:
- Fast-clock (clk) readout request scheduler that sits directly upstream of the clk-to-bclk read-enable stretcher.
- Accumulates trigger requests and issues single-clk read-enable pulses (reI) only when the event FIFO is non-empty.
- Enforces a ratio-dependent holdoff after each pulse, so the downstream stretcher's one-bclk reO completes and clears before the next reI arrives.
- Supports 1:1, 2:1 and 4:1 f(clk)/f(bclk) ratios.

Parameters:
- PEND_W, 4, width of the pending-request counter; saturates at 2^PEND_W-1.
- HOLD_MULT, 3, holdoff length in clk cycles per unit of clock ratio R.

Ports:
- clk  in  1  fast clock; single clock domain.
- rstb  in  1  reset; synchronous, active-low.
- ratioSel  in  2  clock ratio: 00=1:1 (R=1), 01=2:1 (R=2), 10=4:1 (R=4), 11 reserved and treated as R=4.
- enable  in  1  scheduler enable; when low, no new reI is issued.
- trigI  in  1  one-clk request pulse; may be asserted on consecutive cycles.
- fifoEmpty  in  1  event FIFO empty flag.
- clrOvf  in  1  clears the sticky overflow flag.
- reI  out  1  registered read-enable; exactly one clk wide.
- pendCnt  out  PEND_W  number of requests not yet issued.
- busy  out  1  high while in HOLDOFF.
- overflow  out  1  sticky; set when trigI arrives while pendCnt is saturated.

Behaviour:
- Reset: on any posedge clk with rstb=0, all outputs are 0, state=IDLE and the holdoff counter=0.
  - Reset applied mid-HOLDOFF aborts the holdoff immediately.
  - Pending requests are discarded.
- States: IDLE and HOLDOFF.
- Issue condition, evaluated on each edge: state=IDLE && enable=1 && pendCnt!=0 && fifoEmpty=0. When true:
  - reI<=1.
  - pendCnt decrements.
  - holdCnt<=HOLD_MULT*R-1, using R decoded from ratioSel sampled on this edge.
  - state<=HOLDOFF.
- In every other case reI<=0, so reI is never high for two consecutive cycles.
- HOLDOFF: on each edge, if holdCnt=0 then state<=IDLE, else holdCnt decrements.
  - busy = (state==HOLDOFF).
  - ratioSel changes during HOLDOFF do not affect the running count.
- Timing:
  - trigI sampled at edge k with the block idle, FIFO non-empty and enable=1: pendCnt=1 after edge k, reI=1 after edge k+1.
  - Under continuous demand, successive reI rising edges are exactly HOLD_MULT*R+1 clk cycles apart: 4, 7 and 13 cycles for R=1, 2 and 4.
- pendCnt update on each edge:
  - trigI alone: +1.
  - Issue alone: -1.
  - trigI and issue on the same edge: unchanged.
  - trigI with pendCnt=max and no issue: pendCnt stays at max and overflow<=1.
  - No wrap-around in either direction; issue requires pendCnt!=0, so the counter cannot underflow.
- overflow:
  - Cleared by clrOvf=1.
  - If clrOvf and a new overflow event occur on the same edge, set wins.
- enable deasserted mid-HOLDOFF: the holdoff completes normally, then the block remains IDLE with pendCnt held.
- fifoEmpty=1 with pendCnt>0: the block waits in IDLE, and pendCnt keeps accepting triggers.
- fifoEmpty is sampled on the issue edge only; its value during HOLDOFF is ignored.

Decomposition:
- Shared package (abcn_ro_pkg):
  - Ratio codes RATIO_1/2/4.
  - Function ratio_to_r(ratioSel) returning 1, 2 or 4.
  - Default PEND_W and HOLD_MULT.
  - State enum {IDLE, HOLDOFF}.
- One sub-module is natural: holdoff_timer.
  - Inputs: load, loadVal; output: done.
  - Loadable down-counter, 4 bits wide, sized for 3*4-1=11.
- The pending counter and FSM stay in the top module.

Test Plan:
- Reset/latency: rstb=0 for 3 cycles, then release; ratioSel=00, enable=1, fifoEmpty=0; single trigI at edge k -> pendCnt=1 after k, reI=1 after k+1 for exactly one cycle, pendCnt=0 after k+1, busy high for 3 cycles.
- Spacing per ratio: preload 3 triggers, then sweep ratioSel 00/01/10 -> reI rising edges 4/7/13 cycles apart, pendCnt stepping 3,2,1,0; ratioSel=11 gives the same spacing as 10.
- Saturation: 17 back-to-back trigI with enable=0 -> pendCnt=15 and overflow=1 after the 16th trigger; clrOvf=1 together with a further trigI leaves overflow=1; clrOvf alone -> overflow=0.
- Simultaneous trigI/issue: pendCnt=2, trigI asserted on the issue edge -> pendCnt stays 2 and reI=1.
- Gating: pendCnt=2, fifoEmpty=1 for 10 cycles -> reI stays 0; fifoEmpty drops to 0 at edge m -> reI=1 after m. Separately, enable dropped mid-HOLDOFF -> busy completes and no further reI.
- Mid-operation reset: rstb=0 during HOLDOFF with pendCnt=5 -> next edge gives pendCnt=0, busy=0, reI=0, overflow=0; after release, no reI is issued until a new trigI arrives.
